// File: rtl/sos_pkg.sv
// Shared types and default timing for the SOS Morse detector.
package sos_pkg;

  // Matcher progress: which letter of S-O-S is being collected.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    S1   = 2'd1,
    O    = 2'd2,
    S2   = 2'd3
  } state_t;

  // Classified mark.
  typedef enum logic [1:0] {
    SYM_DOT  = 2'd0,
    SYM_DASH = 2'd1,
    SYM_ERR  = 2'd2
  } sym_t;

  localparam int DOT_MAX_D  = 1;
  localparam int DASH_MIN_D = 2;
  localparam int DASH_MAX_D = 4;
  localparam int IDLE_GAP_D = 32;

  // Dot wins when the dot and dash windows overlap.
  function automatic sym_t classify(input int len, input int dot_max,
                                    input int dash_min, input int dash_max);
    if (len >= 1 && len <= dot_max) return SYM_DOT;
    if (len >= dash_min && len <= dash_max) return SYM_DASH;
    return SYM_ERR;
  endfunction

endpackage

// File: rtl/sos_symbol_decoder.sv
// Measures mark/space run lengths on the serial line and classifies each
// finished mark as dot, dash or error. Also flags the edge where the
// space run reaches the idle gap so the matcher can drop partial progress.
module sos_symbol_decoder
  import sos_pkg::*;
#(
  parameter int DOT_MAX  = DOT_MAX_D,
  parameter int DASH_MIN = DASH_MIN_D,
  parameter int DASH_MAX = DASH_MAX_D,
  parameter int IDLE_GAP = IDLE_GAP_D,
  parameter int CNT_W    = 6
)(
  input  logic clk,
  input  logic rst,
  input  logic i_data,
  output logic o_sym_valid,
  output logic o_sym_dash,
  output logic o_sym_err,
  output logic o_gap_hit
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] GAP_M1  = CNT_W'(IDLE_GAP - 1);

  logic             r_d_q;
  logic [CNT_W-1:0] r_mark_cnt;
  logic [CNT_W-1:0] r_space_cnt;
  logic             r_sym_valid;
  logic             r_sym_dash;
  logic             r_sym_err;

  logic w_mark_end;
  sym_t w_sym;

  assign w_mark_end = r_d_q & ~i_data;
  assign w_sym      = classify(int'(r_mark_cnt), DOT_MAX, DASH_MIN, DASH_MAX);
  // Fires on the edge at which the space counter becomes IDLE_GAP; the
  // counter saturates above it, so this happens once per low run.
  assign o_gap_hit  = ~i_data & (r_space_cnt == GAP_M1);

  // Saturating run counters, previous sample and registered classification.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_d_q       <= 1'b0;
      r_mark_cnt  <= '0;
      r_space_cnt <= '0;
      r_sym_valid <= 1'b0;
      r_sym_dash  <= 1'b0;
      r_sym_err   <= 1'b0;
    end else begin
      r_d_q <= i_data;
      if (i_data) begin
        if (r_mark_cnt != CNT_MAX) r_mark_cnt <= r_mark_cnt + 1'b1;
        r_space_cnt <= '0;
      end else begin
        if (r_space_cnt != CNT_MAX) r_space_cnt <= r_space_cnt + 1'b1;
        r_mark_cnt <= '0;
      end
      r_sym_valid <= w_mark_end;
      r_sym_dash  <= w_mark_end && (w_sym == SYM_DASH);
      r_sym_err   <= w_mark_end && (w_sym == SYM_ERR);
    end
  end

  assign o_sym_valid = r_sym_valid;
  assign o_sym_dash  = r_sym_dash;
  assign o_sym_err   = r_sym_err;

endmodule

// File: rtl/sos_detector.sv
// SOS detector: decodes Morse marks from the serial line and pulses
// sos_detected for each non-overlapping dot*3 dash*3 dot*3 sequence.
// Optional det_count output enabled by macro SOS_DET_COUNT_EN.
module sos_detector
  import sos_pkg::*;
#(
  parameter int DOT_MAX  = DOT_MAX_D,
  parameter int DASH_MIN = DASH_MIN_D,
  parameter int DASH_MAX = DASH_MAX_D,
  parameter int IDLE_GAP = IDLE_GAP_D,
  parameter int CNT_W    = 6
)(
  input  logic       clk,
  input  logic       rst,
  input  logic       data_in,
  output logic       sym_valid,
  output logic       sym_dash,
  output logic       sym_err,
  output logic       sos_detected,
  output logic       busy
`ifdef SOS_DET_COUNT_EN
  ,
  output logic [7:0] det_count
`endif
);

  logic w_sym_valid, w_sym_dash, w_sym_err, w_gap_hit;

  sos_symbol_decoder #(
    .DOT_MAX (DOT_MAX),
    .DASH_MIN(DASH_MIN),
    .DASH_MAX(DASH_MAX),
    .IDLE_GAP(IDLE_GAP),
    .CNT_W   (CNT_W)
  ) u_dec (
    .clk        (clk),
    .rst        (rst),
    .i_data     (data_in),
    .o_sym_valid(w_sym_valid),
    .o_sym_dash (w_sym_dash),
    .o_sym_err  (w_sym_err),
    .o_gap_hit  (w_gap_hit)
  );

  state_t     r_state, w_state_nx;
  logic [1:0] r_cnt, w_cnt_nx;
  logic       w_det;

  // Matcher state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  // Next-state and detect pulse; only symbol events or the idle gap move it.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_det      = 1'b0;
    if (w_gap_hit) begin
      w_state_nx = IDLE;
      w_cnt_nx   = 2'd0;
    end else if (w_sym_valid) begin
      if (w_sym_err) begin
        w_state_nx = IDLE;
        w_cnt_nx   = 2'd0;
      end else begin
        unique case (r_state)
          IDLE: begin
            if (!w_sym_dash) begin
              w_state_nx = S1;
              w_cnt_nx   = 2'd1;
            end
          end
          S1: begin
            if (!w_sym_dash) begin
              if (r_cnt != 2'd3) w_cnt_nx = r_cnt + 2'd1;
            end else if (r_cnt == 2'd3) begin
              w_state_nx = O;
              w_cnt_nx   = 2'd1;
            end else begin
              w_state_nx = IDLE;
              w_cnt_nx   = 2'd0;
            end
          end
          O: begin
            if (w_sym_dash) begin
              if (r_cnt != 2'd3) begin
                w_cnt_nx = r_cnt + 2'd1;
              end else begin
                w_state_nx = IDLE;
                w_cnt_nx   = 2'd0;
              end
            end else begin
              // A dot after a short O restarts a fresh S with this dot.
              w_state_nx = (r_cnt == 2'd3) ? S2 : S1;
              w_cnt_nx   = 2'd1;
            end
          end
          S2: begin
            if (!w_sym_dash && r_cnt != 2'd2) begin
              w_cnt_nx = r_cnt + 2'd1;
            end else begin
              w_det      = !w_sym_dash;
              w_state_nx = IDLE;
              w_cnt_nx   = 2'd0;
            end
          end
          default: begin
            w_state_nx = IDLE;
            w_cnt_nx   = 2'd0;
          end
        endcase
      end
    end
  end

  assign sym_valid    = w_sym_valid;
  assign sym_dash     = w_sym_dash;
  assign sym_err      = w_sym_err;
  assign sos_detected = w_det;
  assign busy         = (r_state != IDLE);

`ifdef SOS_DET_COUNT_EN
  logic [7:0] r_det_count;

  // Saturating count of detections.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                r_det_count <= 8'd0;
    else if (w_det && r_det_count != 8'hFF) r_det_count <= r_det_count + 8'd1;
  end

  assign det_count = r_det_count;
`endif

endmodule

// File: tb/tb_sos_detector.sv
// Bench for sos_detector: run-length symbol-history model plus directed
// and randomized Morse traffic. Build with SOS_DET_COUNT_EN to cover det_count.
module tb_sos_detector;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic data_in = 1'b0;
  logic sym_valid, sym_dash, sym_err, sos_detected, busy;
`ifdef SOS_DET_COUNT_EN
  logic [7:0] det_count;
`endif

  sos_detector dut (
    .clk         (clk),
    .rst         (rst),
    .data_in     (data_in),
    .sym_valid   (sym_valid),
    .sym_dash    (sym_dash),
    .sym_err     (sym_err),
    .sos_detected(sos_detected),
    .busy        (busy)
`ifdef SOS_DET_COUNT_EN
    ,
    .det_count   (det_count)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // History of symbol runs since the last clear: t=1 dots, t=2 dashes.
  typedef struct {int t; int n;} run_t;
  run_t hist[$];

  int m_prev = 0, m_hi = 0, m_lo = 0, m_det = 0;
  bit e_valid = 0, e_dash = 0, e_err = 0, e_sos = 0, e_busy = 0;
  int e_cnt = 0;

  // Partial match alive: ending in dots, or in at most 3 dashes that follow >=3 dots.
  function automatic bit busy_of();
    if (hist.size() == 0) return 1'b0;
    if (hist[$].t == 1) return 1'b1;
    if (hist[$].n <= 3 && hist.size() >= 2 && hist[$-1].n >= 3) return 1'b1;
    return 1'b0;
  endfunction

  // s: 0 dot, 1 dash, 2 error. Returns 1 when the history completes SOS.
  function automatic bit apply_sym(input int s);
    int  t;
    bit  hit;
    if (s == 2) begin
      hist.delete();
      return 1'b0;
    end
    t = (s == 0) ? 1 : 2;
    if (hist.size() > 0 && hist[$].t == t) hist[$].n = hist[$].n + 1;
    else hist.push_back('{t, 1});
    hit = (t == 1) && hist.size() >= 3 && hist[$].n == 3 &&
          hist[$-1].n == 3 && hist[$-2].n >= 3;
    if (hit) hist.delete();
    return hit;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hist.delete();
      m_prev = 0; m_hi = 0; m_lo = 0; m_det = 0;
      e_valid = 0; e_dash = 0; e_err = 0; e_sos = 0; e_busy = 0; e_cnt = 0;
    end else begin
      bit me;
      int len, s;
      e_cnt   = (m_det > 255) ? 255 : m_det;
      me      = (m_prev == 1) && !data_in;
      e_valid = 0; e_dash = 0; e_err = 0; e_sos = 0;
      if (me) begin
        len     = m_hi;
        s       = (len >= 1 && len <= 1) ? 0 : (len >= 2 && len <= 4) ? 1 : 2;
        e_valid = 1;
        e_dash  = (s == 1);
        e_err   = (s == 2);
        e_busy  = busy_of();
        e_sos   = apply_sym(s);
        if (e_sos) m_det++;
      end
      if (data_in) begin m_hi++; m_lo = 0; end
      else begin m_lo++; m_hi = 0; end
      if (!data_in && m_lo == 32) hist.delete();
      if (!me) e_busy = busy_of();
      m_prev = data_in;
    end
  end

  // ---------------- checking / stimulus ----------------
  int n_tests = 0, n_fail = 0;
  int dut_sos = 0, dut_valid = 0, dut_err = 0;
  logic [31:0] dash_pat = '0;

  task automatic check(input string nm, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // One clock: compare outputs with the model, then drive the next sample.
  task automatic tick(input logic d);
    @(negedge clk);
    n_tests++;
    if ({sym_valid, sym_dash, sym_err, sos_detected, busy} !==
        {e_valid, e_dash, e_err, e_sos, e_busy}) begin
      n_fail++;
      $display("FAIL cycle t=%0t valid/dash/err/sos/busy got %b%b%b%b%b expected %b%b%b%b%b",
               $time, sym_valid, sym_dash, sym_err, sos_detected, busy,
               e_valid, e_dash, e_err, e_sos, e_busy);
    end
`ifdef SOS_DET_COUNT_EN
    n_tests++;
    if (int'(det_count) != e_cnt) begin
      n_fail++;
      $display("FAIL det_count t=%0t got %0d expected %0d", $time, det_count, e_cnt);
    end
`endif
    if (sym_valid) begin
      dut_valid++;
      dash_pat = {dash_pat[30:0], sym_dash};
      if (sym_err) dut_err++;
    end
    if (sos_detected) dut_sos++;
    data_in = d;
  endtask

  task automatic mark(input int len, input int gap);
    repeat (len) tick(1'b1);
    repeat (gap) tick(1'b0);
  endtask

  task automatic letter_s(); repeat (3) mark(1, 2); endtask
  task automatic letter_o(); repeat (3) mark(3, 2); endtask
  task automatic send_sos(); letter_s(); letter_o(); letter_s(); endtask

  task automatic do_reset();
    tick(1'b0);
    rst = 1'b1;
    tick(1'b0);
    rst = 1'b0;
  endtask

  int s0, v0, md0, e0;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_sym_valid", sym_valid, 0);
    check("rst_sym_dash", sym_dash, 0);
    check("rst_sym_err", sym_err, 0);
    check("rst_sos", sos_detected, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    repeat (3) tick(1'b0);

    // Plain SOS with 2-cycle spaces.
    s0 = dut_sos; v0 = dut_valid; md0 = m_det; dash_pat = '0;
    send_sos();
    repeat (3) tick(1'b0);
    check("t1_valid_count", dut_valid - v0, 9);
    check("t1_dash_pattern", int'(dash_pat[8:0]), 9'b000111000);
    check("t1_sos_count", dut_sos - s0, 1);
    check("t1_model_det", m_det - md0, 1);
    check("t1_busy_after", busy, 0);

    // Five dots saturate the first S.
    s0 = dut_sos;
    repeat (2) mark(1, 2);
    send_sos();
    repeat (3) tick(1'b0);
    check("t2_sos_count", dut_sos - s0, 1);

    // Long space after S O clears progress.
    s0 = dut_sos;
    letter_s(); letter_o();
    check("t3_busy_mid", busy, 1);
    repeat (40) tick(1'b0);
    check("t3_busy_gap", busy, 0);
    letter_s();
    check("t3_busy_new_s", busy, 1);
    repeat (35) tick(1'b0);
    check("t3_sos_count", dut_sos - s0, 0);

    // A 6-cycle mark inside the O is an error.
    s0 = dut_sos; e0 = dut_err;
    letter_s(); mark(3, 2); mark(6, 2); mark(3, 2); letter_s();
    repeat (3) tick(1'b0);
    check("t4_err_count", dut_err - e0, 1);
    check("t4_sos_count", dut_sos - s0, 0);
    repeat (35) tick(1'b0);

    // Reset in the middle of an O, then a full SOS.
    s0 = dut_sos;
    letter_s(); mark(3, 2); mark(3, 2);
    check("t5_busy_pre_rst", busy, 1);
    do_reset();
    check("t5_busy_post_rst", busy, 0);
    send_sos();
    repeat (3) tick(1'b0);
    check("t5_sos_count", dut_sos - s0, 1);

    // Randomized traffic: real SOS words mixed with arbitrary marks/gaps.
    for (int i = 0; i < 300; i++) begin
      int r, len, gap;
      r = $urandom_range(0, 59);
      if (r == 0) begin
        do_reset();
      end else if (r < 18) begin
        for (int k = 0; k < 9; k++) begin
          len = (k >= 3 && k < 6) ? $urandom_range(2, 4) : 1;
          mark(len, $urandom_range(1, 3));
        end
      end else begin
        case ($urandom_range(0, 9))
          0, 1, 2: len = 1;
          3, 4:    len = 3;
          5:       len = 2;
          6:       len = 4;
          7:       len = 5;
          8:       len = $urandom_range(6, 9);
          default: len = ($urandom_range(0, 3) == 0) ? 70 : 1;
        endcase
        gap = ($urandom_range(0, 14) == 0) ? 35 : $urandom_range(1, 4);
        mark(len, gap);
      end
    end
    repeat (5) tick(1'b0);

`ifdef SOS_DET_COUNT_EN
    do_reset();
    repeat (3) send_sos();
    repeat (3) tick(1'b0);
    check("cnt_three", int'(det_count), 3);
    repeat (297) send_sos();
    repeat (3) tick(1'b0);
    check("cnt_saturate", int'(det_count), 255);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
